mc_axi_arb2: RTL and testbench



---
 rtl/mc_axi_arb2.sv | 246 ++++++++++++++++++++++++
 tb/tb_mc_axi_arb2.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_axi_arb2.sv
// mc_axi_arb2: two-master to one-slave AXI4 arbiter in front of the DDR4 AXI port.
// Writes and reads are arbitrated independently, each round-robin. The slave-side
// ID carries a master-select bit in its MSB, and B/R responses are routed on that bit.
// No new grants are issued until calib_done is high.
// Ports:
//   mc_clk, mc_rst        clock, asynchronous active-high reset
//   calib_done            DDR4 calibration complete; gates new grants
//   s0_axi_*, s1_axi_*    AXI4 slave ports facing master 0 (NoC bridge) and master 1 (DMA)
//   m_axi_*               AXI4 master port toward the DDR4 controller (ID is ID_WIDTH+1 wide)
module mc_axi_arb2 #(
    parameter int unsigned ID_WIDTH   = 15,
    parameter int unsigned ADDR_WIDTH = 35,
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                      mc_clk,
    input  logic                      mc_rst,
    input  logic                      calib_done,
    // master 0
    input  logic [ID_WIDTH-1:0]       s0_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_awaddr,
    input  logic [7:0]                s0_axi_awlen,
    input  logic [2:0]                s0_axi_awsize,
    input  logic [1:0]                s0_axi_awburst,
    input  logic                      s0_axi_awvalid,
    output logic                      s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axi_wstrb,
    input  logic                      s0_axi_wlast,
    input  logic                      s0_axi_wvalid,
    output logic                      s0_axi_wready,
    output logic [ID_WIDTH-1:0]       s0_axi_bid,
    output logic [1:0]                s0_axi_bresp,
    output logic                      s0_axi_bvalid,
    input  logic                      s0_axi_bready,
    input  logic [ID_WIDTH-1:0]       s0_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_araddr,
    input  logic [7:0]                s0_axi_arlen,
    input  logic [2:0]                s0_axi_arsize,
    input  logic [1:0]                s0_axi_arburst,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [ID_WIDTH-1:0]       s0_axi_rid,
    output logic [DATA_WIDTH-1:0]     s0_axi_rdata,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rlast,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready,
    // master 1
    input  logic [ID_WIDTH-1:0]       s1_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_awaddr,
    input  logic [7:0]                s1_axi_awlen,
    input  logic [2:0]                s1_axi_awsize,
    input  logic [1:0]                s1_axi_awburst,
    input  logic                      s1_axi_awvalid,
    output logic                      s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_axi_wstrb,
    input  logic                      s1_axi_wlast,
    input  logic                      s1_axi_wvalid,
    output logic                      s1_axi_wready,
    output logic [ID_WIDTH-1:0]       s1_axi_bid,
    output logic [1:0]                s1_axi_bresp,
    output logic                      s1_axi_bvalid,
    input  logic                      s1_axi_bready,
    input  logic [ID_WIDTH-1:0]       s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_araddr,
    input  logic [7:0]                s1_axi_arlen,
    input  logic [2:0]                s1_axi_arsize,
    input  logic [1:0]                s1_axi_arburst,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [ID_WIDTH-1:0]       s1_axi_rid,
    output logic [DATA_WIDTH-1:0]     s1_axi_rdata,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rlast,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready,
    // DDR4 slave side
    output logic [ID_WIDTH:0]         m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic [3:0]                m_axi_awregion,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH:0]         m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ID_WIDTH:0]         m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [ID_WIDTH:0]         m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wstate_e;
    typedef enum logic       {R_IDLE, R_ADDR}         rstate_e;

    wstate_e wstate_q;
    rstate_e rstate_q;
    logic    wgnt_q, wlast_gnt_q;
    logic    rgnt_q, rlast_gnt_q;
    logic    w_pick, r_pick;
    logic    w_addr, w_data, r_addr;
    logic    bsel, rsel;

    // Round-robin pick: on contention the master not served last wins.
    assign w_pick = (s0_axi_awvalid && s1_axi_awvalid) ? ~wlast_gnt_q : s1_axi_awvalid;
    assign r_pick = (s0_axi_arvalid && s1_axi_arvalid) ? ~rlast_gnt_q : s1_axi_arvalid;

    assign w_addr = (wstate_q == W_ADDR);
    assign w_data = (wstate_q == W_DATA);
    assign r_addr = (rstate_q == R_ADDR);

    // Write FSM: grant, address phase, then the whole data burst of that master.
    always_ff @(posedge mc_clk or posedge mc_rst) begin
        if (mc_rst) begin
            wstate_q    <= W_IDLE;
            wgnt_q      <= 1'b0;
            wlast_gnt_q <= 1'b1;
        end else begin
            case (wstate_q)
                W_IDLE: if (calib_done && (s0_axi_awvalid || s1_axi_awvalid)) begin
                    wgnt_q   <= w_pick;
                    wstate_q <= W_ADDR;
                end
                W_ADDR: if (m_axi_awvalid && m_axi_awready) wstate_q <= W_DATA;
                W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                    wlast_gnt_q <= wgnt_q;
                    wstate_q    <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: only the address phase is held; data returns are routed by ID.
    always_ff @(posedge mc_clk or posedge mc_rst) begin
        if (mc_rst) begin
            rstate_q    <= R_IDLE;
            rgnt_q      <= 1'b0;
            rlast_gnt_q <= 1'b1;
        end else begin
            case (rstate_q)
                R_IDLE: if (calib_done && (s0_axi_arvalid || s1_axi_arvalid)) begin
                    rgnt_q   <= r_pick;
                    rstate_q <= R_ADDR;
                end
                R_ADDR: if (m_axi_arvalid && m_axi_arready) begin
                    rlast_gnt_q <= rgnt_q;
                    rstate_q    <= R_IDLE;
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // AW mux; the master-select bit is prepended to the ID.
    assign m_axi_awid     = {wgnt_q, wgnt_q ? s1_axi_awid : s0_axi_awid};
    assign m_axi_awaddr   = wgnt_q ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m_axi_awlen    = wgnt_q ? s1_axi_awlen   : s0_axi_awlen;
    assign m_axi_awsize   = wgnt_q ? s1_axi_awsize  : s0_axi_awsize;
    assign m_axi_awburst  = wgnt_q ? s1_axi_awburst : s0_axi_awburst;
    assign m_axi_awvalid  = w_addr && (wgnt_q ? s1_axi_awvalid : s0_axi_awvalid);
    assign s0_axi_awready = w_addr && !wgnt_q && m_axi_awready;
    assign s1_axi_awready = w_addr &&  wgnt_q && m_axi_awready;

    // W mux; data offered outside the granted data phase is stalled.
    assign m_axi_wdata    = wgnt_q ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb    = wgnt_q ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wlast    = wgnt_q ? s1_axi_wlast : s0_axi_wlast;
    assign m_axi_wvalid   = w_data && (wgnt_q ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready  = w_data && !wgnt_q && m_axi_wready;
    assign s1_axi_wready  = w_data &&  wgnt_q && m_axi_wready;

    // AR mux
    assign m_axi_arid     = {rgnt_q, rgnt_q ? s1_axi_arid : s0_axi_arid};
    assign m_axi_araddr   = rgnt_q ? s1_axi_araddr  : s0_axi_araddr;
    assign m_axi_arlen    = rgnt_q ? s1_axi_arlen   : s0_axi_arlen;
    assign m_axi_arsize   = rgnt_q ? s1_axi_arsize  : s0_axi_arsize;
    assign m_axi_arburst  = rgnt_q ? s1_axi_arburst : s0_axi_arburst;
    assign m_axi_arvalid  = r_addr && (rgnt_q ? s1_axi_arvalid : s0_axi_arvalid);
    assign s0_axi_arready = r_addr && !rgnt_q && m_axi_arready;
    assign s1_axi_arready = r_addr &&  rgnt_q && m_axi_arready;

    // Attributes not carried by the masters
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'd0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;

    // B routing on the ID MSB
    assign bsel          = m_axi_bid[ID_WIDTH];
    assign s0_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
    assign s1_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
    assign s0_axi_bresp  = m_axi_bresp;
    assign s1_axi_bresp  = m_axi_bresp;
    assign s0_axi_bvalid = m_axi_bvalid && !bsel;
    assign s1_axi_bvalid = m_axi_bvalid &&  bsel;
    assign m_axi_bready  = bsel ? s1_axi_bready : s0_axi_bready;

    // R routing on the ID MSB
    assign rsel          = m_axi_rid[ID_WIDTH];
    assign s0_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
    assign s1_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
    assign s0_axi_rdata  = m_axi_rdata;
    assign s1_axi_rdata  = m_axi_rdata;
    assign s0_axi_rresp  = m_axi_rresp;
    assign s1_axi_rresp  = m_axi_rresp;
    assign s0_axi_rlast  = m_axi_rlast;
    assign s1_axi_rlast  = m_axi_rlast;
    assign s0_axi_rvalid = m_axi_rvalid && !rsel;
    assign s1_axi_rvalid = m_axi_rvalid &&  rsel;
    assign m_axi_rready  = rsel ? s1_axi_rready : s0_axi_rready;

endmodule

// File: tb/tb_mc_axi_arb2.sv
// tb_mc_axi_arb2: directed bench for mc_axi_arb2. The bench plays both masters and
// the DDR4 slave; inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_mc_axi_arb2;

    localparam int unsigned IDW = 15;
    localparam int unsigned ADW = 35;
    localparam int unsigned DW  = 512;
    localparam int unsigned SW  = DW / 8;

    logic mc_clk, mc_rst, calib_done;

    logic [IDW-1:0] s0_awid, s1_awid, s0_arid, s1_arid;
    logic [ADW-1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr;
    logic [7:0]     s0_awlen, s1_awlen, s0_arlen, s1_arlen;
    logic [2:0]     s0_awsize, s1_awsize, s0_arsize, s1_arsize;
    logic [1:0]     s0_awburst, s1_awburst, s0_arburst, s1_arburst;
    logic           s0_awvalid, s1_awvalid, s0_arvalid, s1_arvalid;
    logic           s0_awready, s1_awready, s0_arready, s1_arready;
    logic [DW-1:0]  s0_wdata, s1_wdata;
    logic [SW-1:0]  s0_wstrb, s1_wstrb;
    logic           s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
    logic [IDW-1:0] s0_bid, s1_bid, s0_rid, s1_rid;
    logic [1:0]     s0_bresp, s1_bresp, s0_rresp, s1_rresp;
    logic           s0_bvalid, s1_bvalid, s0_bready, s1_bready;
    logic [DW-1:0]  s0_rdata, s1_rdata;
    logic           s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;

    logic [IDW:0]   m_awid, m_arid, m_bid, m_rid;
    logic [ADW-1:0] m_awaddr, m_araddr;
    logic [7:0]     m_awlen, m_arlen;
    logic [2:0]     m_awsize, m_arsize, m_awprot, m_arprot;
    logic [1:0]     m_awburst, m_arburst, m_bresp, m_rresp;
    logic           m_awlock, m_arlock;
    logic [3:0]     m_awcache, m_arcache, m_awqos, m_arqos, m_awregion, m_arregion;
    logic           m_awvalid, m_awready, m_arvalid, m_arready;
    logic [DW-1:0]  m_wdata, m_rdata;
    logic [SW-1:0]  m_wstrb;
    logic           m_wlast, m_wvalid, m_wready;
    logic           m_bvalid, m_bready, m_rlast, m_rvalid, m_rready;

    int n_assert = 0;
    int n_fail   = 0;

    mc_axi_arb2 #(.ID_WIDTH(IDW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) dut (
        .mc_clk(mc_clk), .mc_rst(mc_rst), .calib_done(calib_done),
        .s0_axi_awid(s0_awid), .s0_axi_awaddr(s0_awaddr), .s0_axi_awlen(s0_awlen),
        .s0_axi_awsize(s0_awsize), .s0_axi_awburst(s0_awburst), .s0_axi_awvalid(s0_awvalid),
        .s0_axi_awready(s0_awready), .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb),
        .s0_axi_wlast(s0_wlast), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(s0_wready),
        .s0_axi_bid(s0_bid), .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid),
        .s0_axi_bready(s0_bready), .s0_axi_arid(s0_arid), .s0_axi_araddr(s0_araddr),
        .s0_axi_arlen(s0_arlen), .s0_axi_arsize(s0_arsize), .s0_axi_arburst(s0_arburst),
        .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready), .s0_axi_rid(s0_rid),
        .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rlast(s0_rlast),
        .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s0_rready),
        .s1_axi_awid(s1_awid), .s1_axi_awaddr(s1_awaddr), .s1_axi_awlen(s1_awlen),
        .s1_axi_awsize(s1_awsize), .s1_axi_awburst(s1_awburst), .s1_axi_awvalid(s1_awvalid),
        .s1_axi_awready(s1_awready), .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb),
        .s1_axi_wlast(s1_wlast), .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(s1_wready),
        .s1_axi_bid(s1_bid), .s1_axi_bresp(s1_bresp), .s1_axi_bvalid(s1_bvalid),
        .s1_axi_bready(s1_bready), .s1_axi_arid(s1_arid), .s1_axi_araddr(s1_araddr),
        .s1_axi_arlen(s1_arlen), .s1_axi_arsize(s1_arsize), .s1_axi_arburst(s1_arburst),
        .s1_axi_arvalid(s1_arvalid), .s1_axi_arready(s1_arready), .s1_axi_rid(s1_rid),
        .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp), .s1_axi_rlast(s1_rlast),
        .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(s1_rready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock),
        .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot), .m_axi_awqos(m_awqos),
        .m_axi_awregion(m_awregion), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
        .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos),
        .m_axi_arregion(m_arregion), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    initial mc_clk = 1'b0;
    always #5 mc_clk = ~mc_clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected end before 200000 ns");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] pat(input int unsigned m, input int unsigned b);
        return {16{32'(m * 256 + b)}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic nxt();
        @(negedge mc_clk);
    endtask

    initial begin
        int b, c, cnt;
        mc_rst = 1'b1; calib_done = 1'b0;
        s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awsize = 3'd6; s0_awburst = 2'd1; s0_awvalid = 1'b0;
        s1_awid = '0; s1_awaddr = '0; s1_awlen = '0; s1_awsize = 3'd6; s1_awburst = 2'd1; s1_awvalid = 1'b0;
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd6; s0_arburst = 2'd1; s0_arvalid = 1'b0;
        s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd6; s1_arburst = 2'd1; s1_arvalid = 1'b0;
        s0_wdata = '0; s0_wstrb = '1; s0_wlast = 1'b0; s0_wvalid = 1'b0;
        s1_wdata = '0; s1_wstrb = '1; s1_wlast = 1'b0; s1_wvalid = 1'b0;
        s0_bready = 1'b0; s1_bready = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

        // Reset state
        nxt(); #1;
        chk("rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_readies", 64'({s0_awready, s1_awready, s0_wready, s1_wready, s0_arready, s1_arready}), 64'd0);
        chk("tie_attrs", 64'({m_awlock, m_awcache, m_awprot, m_awqos, m_awregion,
                              m_arlock, m_arcache, m_arprot, m_arqos, m_arregion}), 64'd0);

        // Calibration gating, single-beat write from master 1
        nxt(); mc_rst = 1'b0;
        s1_awvalid = 1'b1; s1_awid = 15'h5; s1_awlen = 8'd0; s1_awaddr = 35'h1_0000_0040;
        for (int i = 0; i < 10; i++) begin
            nxt(); #1;
            chk("calib_gate", 64'(m_awvalid), 64'd0);
        end
        nxt(); calib_done = 1'b1; #1;
        chk("calib_same_cycle", 64'(m_awvalid), 64'd0);
        nxt(); #1;
        chk("calib_awvalid", 64'(m_awvalid), 64'd1);
        chk("calib_awid", 64'(m_awid), 64'h8005);
        chk("calib_awaddr", 64'(m_awaddr), 64'h1_0000_0040);
        chk("calib_awready_hold", 64'(s1_awready), 64'd0);
        m_awready = 1'b1; #1;
        chk("calib_awready", 64'({s0_awready, s1_awready}), 64'b01);
        nxt();
        s1_awvalid = 1'b0;
        s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = pat(1, 0); m_wready = 1'b1; #1;
        chk("len0_wvalid", 64'(m_wvalid), 64'd1);
        chk("len0_wready", 64'({s0_wready, s1_wready}), 64'b01);
        chkd("len0_wdata", m_wdata, pat(1, 0));
        nxt(); #1;
        chk("len0_idle", 64'(m_wvalid), 64'd0);
        s1_wvalid = 1'b0;

        // Contention: both len 3, ID 5; master 0 first
        s0_awvalid = 1'b1; s0_awid = 15'h5; s0_awlen = 8'd3;
        s1_awvalid = 1'b1; s1_awid = 15'h5; s1_awlen = 8'd3;
        s1_wvalid = 1'b1; s1_wdata = pat(1, 0); s1_wlast = 1'b0; #1;
        chk("cont_idle", 64'(m_awvalid), 64'd0);
        chk("cont_early_w", 64'(s1_wready), 64'd0);
        nxt(); #1;
        chk("cont_awid0", 64'(m_awid), 64'h0005);
        chk("cont_awlen0", 64'(m_awlen), 64'd3);
        chk("cont_awready0", 64'({s0_awready, s1_awready}), 64'b10);
        nxt(); s0_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s0_wvalid = 1'b1; s0_wdata = pat(0, i); s0_wlast = (i == 3); #1;
            chkd("cont_wdata0", m_wdata, pat(0, i));
            chk("cont_wlast0", 64'(m_wlast), 64'(i == 3));
            chk("cont_wready0", 64'({s0_wready, s1_wready, s1_awready}), 64'b100);
            nxt();
        end
        s0_wvalid = 1'b0; #1;
        chk("cont_gap", 64'(m_awvalid), 64'd0);
        nxt(); #1;
        chk("cont_awid1", 64'(m_awid), 64'h8005);
        chk("cont_awready1", 64'({s0_awready, s1_awready}), 64'b01);
        nxt(); s1_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s1_wvalid = 1'b1; s1_wdata = pat(1, i); s1_wlast = (i == 3); #1;
            chkd("cont_wdata1", m_wdata, pat(1, i));
            chk("cont_wready1", 64'({s0_wready, s1_wready}), 64'b01);
            nxt();
        end
        s1_wvalid = 1'b0;

        // Round-robin: master 0 issues 4 len-0 writes, master 1 requests throughout
        s0_awvalid = 1'b1; s0_awid = 15'h3; s0_awlen = 8'd0;
        s1_awvalid = 1'b1; s1_awid = 15'h3; s1_awlen = 8'd0;
        s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = pat(0, 7);
        s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = pat(1, 7); #1;
        chk("rr_idle", 64'(m_awvalid), 64'd0);
        for (int k = 0; k < 8; k++) begin
            nxt(); #1;
            chk("rr_awvalid", 64'(m_awvalid), 64'd1);
            chk("rr_order", 64'(m_awid), (k % 2 == 1) ? 64'h8003 : 64'h0003);
            nxt();
            if (k == 6) s0_awvalid = 1'b0;
            if (k == 7) s1_awvalid = 1'b0;
            #1;
            chk("rr_wready", 64'({s0_wready, s1_wready}), (k % 2 == 1) ? 64'b01 : 64'b10);
            nxt(); #1;
            chk("rr_back_idle", 64'(m_wvalid), 64'd0);
        end
        s0_wvalid = 1'b0; s1_wvalid = 1'b0;

        // Write backpressure: len 7, slave wready toggling
        s0_awvalid = 1'b1; s0_awid = 15'h7; s0_awlen = 8'd7;
        nxt(); #1;
        chk("bp_awlen", 64'(m_awlen), 64'd7);
        nxt(); s0_awvalid = 1'b0;
        b = 0; c = 0; cnt = 0;
        while (b < 8 && c < 40) begin
            m_wready = (c % 2 == 0);
            s0_wvalid = 1'b1; s0_wdata = pat(0, 16 + b); s0_wlast = (b == 7); #1;
            chkd("bp_data", m_wdata, pat(0, 16 + b));
            chk("bp_wready", 64'(s0_wready), 64'(c % 2 == 0));
            if (m_wvalid && m_wready) cnt++;
            if (m_wready) b++;
            c++;
            nxt();
        end
        #1;
        chk("bp_bound", 64'(b), 64'd8);
        chk("bp_beats", 64'(cnt), 64'd8);
        chk("bp_idle_wvalid", 64'(m_wvalid), 64'd0);
        chk("bp_idle_wready", 64'(s0_wready), 64'd0);
        s0_wvalid = 1'b0; m_wready = 1'b1;

        // Read routing
        m_arready = 1'b1; s0_arvalid = 1'b1; s0_arid = 15'h1; #1;
        chk("rd_idle", 64'(m_arvalid), 64'd0);
        nxt(); #1;
        chk("rd_arvalid0", 64'(m_arvalid), 64'd1);
        chk("rd_arid0", 64'(m_arid), 64'h0001);
        chk("rd_arready0", 64'({s0_arready, s1_arready}), 64'b10);
        nxt(); s0_arvalid = 1'b0; s1_arvalid = 1'b1; s1_arid = 15'h1; #1;
        chk("rd_gap", 64'(m_arvalid), 64'd0);
        nxt(); #1;
        chk("rd_arid1", 64'(m_arid), 64'h8001);
        chk("rd_arready1", 64'({s0_arready, s1_arready}), 64'b01);
        nxt(); s1_arvalid = 1'b0;
        m_rid = 16'h8001; m_rdata = pat(9, 1); m_rlast = 1'b1; m_rvalid = 1'b1;
        s1_rready = 1'b1; s0_rready = 1'b0; #1;
        chk("r1_valid", 64'({s0_rvalid, s1_rvalid}), 64'b01);
        chk("r1_rid", 64'(s1_rid), 64'h1);
        chkd("r1_data", s1_rdata, pat(9, 1));
        chk("r1_rready", 64'(m_rready), 64'd1);
        s1_rready = 1'b0; #1;
        chk("r1_rready_low", 64'(m_rready), 64'd0);
        nxt();
        m_rid = 16'h0001; m_rdata = pat(9, 0); s0_rready = 1'b1; #1;
        chk("r0_valid", 64'({s0_rvalid, s1_rvalid}), 64'b10);
        chk("r0_rid", 64'(s0_rid), 64'h1);
        chkd("r0_data", s0_rdata, pat(9, 0));
        chk("r0_rready", 64'(m_rready), 64'd1);
        m_rvalid = 1'b0; #1;
        chk("r_none", 64'({s0_rvalid, s1_rvalid}), 64'b00);
        m_bid = 16'h8005; m_bresp = 2'd2; m_bvalid = 1'b1; s1_bready = 1'b1; s0_bready = 1'b0; #1;
        chk("b1_valid", 64'({s0_bvalid, s1_bvalid}), 64'b01);
        chk("b1_id_resp", 64'({s1_bid, s1_bresp}), 64'({15'h5, 2'd2}));
        chk("b1_bready", 64'(m_bready), 64'd1);
        m_bid = 16'h0004; #1;
        chk("b0_valid", 64'({s0_bvalid, s1_bvalid}), 64'b10);
        chk("b0_bready", 64'(m_bready), 64'd0);
        m_bvalid = 1'b0;

        // Simultaneous write and read, then reset mid-burst
        nxt();
        s0_awvalid = 1'b1; s0_awid = 15'h2; s0_awlen = 8'd3;
        s1_arvalid = 1'b1; s1_arid = 15'h2; m_arready = 1'b0;
        nxt(); #1;
        chk("sim_awvalid", 64'(m_awvalid), 64'd1);
        chk("sim_arvalid", 64'(m_arvalid), 64'd1);
        chk("sim_arid", 64'(m_arid), 64'h8002);
        nxt(); s0_awvalid = 1'b0;
        s0_wvalid = 1'b1; s0_wdata = pat(0, 32); s0_wlast = 1'b0; #1;
        chk("mid_beat0", 64'(m_wvalid), 64'd1);
        nxt(); s0_wdata = pat(0, 33);
        nxt(); s0_wdata = pat(0, 34); mc_rst = 1'b1; #1;
        chk("mid_rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("mid_rst_wvalid", 64'(m_wvalid), 64'd0);
        chk("mid_rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("mid_rst_readies", 64'({s0_wready, s1_arready}), 64'd0);
        nxt(); mc_rst = 1'b0; s0_wvalid = 1'b0; s1_arvalid = 1'b0;
        s0_awvalid = 1'b1; s1_awvalid = 1'b1; s1_awid = 15'h2; m_awready = 1'b1; #1;
        chk("post_rst_idle", 64'(m_awvalid), 64'd0);
        nxt(); #1;
        chk("post_rst_gnt", 64'(m_awid), 64'h0002);
        chk("post_rst_awready", 64'({s0_awready, s1_awready}), 64'b10);
        s0_awvalid = 1'b0; s1_awvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
